// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix multiply engine.
// Holds the FSM state encoding, default dimension and matrix base addresses.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_A,
    READ_B,
    WRITE,
    DONE
  } mm_state_e;

  localparam int unsigned MM_N_DEFAULT = 3;
  localparam int unsigned MM_A_BASE    = 0;
  localparam int unsigned MM_B_BASE    = 9;
  localparam int unsigned MM_C_BASE    = 18;

  // Row-major word address of element [row][col] in an n-wide matrix.
  function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                            input logic [31:0] row,
                                            input logic [31:0] col,
                                            input logic [31:0] n);
    return base + row * n + col;
  endfunction

endpackage

// File: rtl/matrix_mult_engine_if.sv
// Control and data-memory bus of the matrix multiply engine.
// master = engine side, slave = requester / memory side.
interface matrix_mult_engine_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;

  modport master (
    input  start,
    input  mem_read_data,
    output busy,
    output done,
    output overflow,
    output mem_address,
    output mem_write_data,
    output mem_write_enable,
    output mem_read_enable
  );

  modport slave (
    output start,
    output mem_read_data,
    input  busy,
    input  done,
    input  overflow,
    input  mem_address,
    input  mem_write_data,
    input  mem_write_enable,
    input  mem_read_enable
  );
endinterface

// File: rtl/mac_unit.sv
// Operand/accumulator datapath: 32-bit modulo multiply-accumulate.
// Optional sticky overflow detection when MATMUL_OVF_FLAG_EN is defined.
module mac_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_load_op,
  input  logic        i_mac_en,
  input  logic        i_acc_clr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_acc_next,
  output logic        o_overflow
);

  logic [31:0] r_operand;
  logic [31:0] r_acc;

`ifdef MATMUL_OVF_FLAG_EN
  logic [63:0] w_prod;
  logic [32:0] w_sum;
  logic        r_ovf;

  assign w_prod     = {32'd0, r_operand} * {32'd0, i_rd_data};
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod[31:0]};
  assign o_acc_next = w_sum[31:0];
  assign o_overflow = r_ovf;

  // Sticky until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (i_start) begin
      r_ovf <= 1'b0;
    end else if (i_mac_en && ((|w_prod[63:32]) || w_sum[32])) begin
      r_ovf <= 1'b1;
    end
  end
`else
  logic [31:0] w_prod;

  assign w_prod     = r_operand * i_rd_data;
  assign o_acc_next = r_acc + w_prod;
  assign o_overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand <= '0;
      r_acc     <= '0;
    end else if (i_start) begin
      r_operand <= '0;
      r_acc     <= '0;
    end else begin
      if (i_load_op) begin
        r_operand <= i_rd_data;
      end
      if (i_mac_en) begin
        r_acc <= o_acc_next;
      end else if (i_acc_clr) begin
        r_acc <= '0;
      end
    end
  end

endmodule

// File: rtl/matrix_mult_engine.sv
// Sequential C = A*B engine over a single-port word memory, one MAC per A/B read pair.
// Define MATMUL_OVF_FLAG_EN to build the sticky overflow flag (otherwise tied to 0).
module matrix_mult_engine
  import matmul_pkg::*;
#(
  parameter int unsigned N      = MM_N_DEFAULT,
  parameter int unsigned A_BASE = MM_A_BASE,
  parameter int unsigned B_BASE = MM_B_BASE,
  parameter int unsigned C_BASE = MM_C_BASE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_mult_engine_if.master  bus
);

  localparam logic [31:0] LAST = 32'(N - 1);
  localparam logic [31:0] NW   = 32'(N);
  localparam logic [31:0] AB   = 32'(A_BASE);
  localparam logic [31:0] BB   = 32'(B_BASE);
  localparam logic [31:0] CB   = 32'(C_BASE);

  mm_state_e   r_state;
  logic [31:0] r_i;
  logic [31:0] r_j;
  logic [31:0] r_k;
  logic        r_busy;
  logic        r_done;
  logic        r_re;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_start;
  logic        w_load_op;
  logic        w_mac_en;
  logic        w_acc_clr;
  logic [31:0] w_acc_next;
  logic        w_overflow;

  assign w_start   = (r_state == IDLE) && bus.start;
  assign w_load_op = (r_state == READ_A);
  assign w_mac_en  = (r_state == READ_B);
  assign w_acc_clr = (r_state == WRITE);

  mac_unit u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_load_op  (w_load_op),
    .i_mac_en   (w_mac_en),
    .i_acc_clr  (w_acc_clr),
    .i_rd_data  (bus.mem_read_data),
    .o_acc_next (w_acc_next),
    .o_overflow (w_overflow)
  );

  // Bus outputs are registered: each transition loads the values of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= READ_A;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_re    <= 1'b1;
            r_addr  <= elem_addr(AB, '0, '0, NW);
          end
        end
        READ_A: begin
          r_state <= READ_B;
          r_addr  <= elem_addr(BB, r_k, r_j, NW);
        end
        READ_B: begin
          if (r_k != LAST) begin
            r_state <= READ_A;
            r_k     <= r_k + 32'd1;
            r_addr  <= elem_addr(AB, r_i, r_k + 32'd1, NW);
          end else begin
            // Write data is the accumulator value produced by this final MAC.
            r_state <= WRITE;
            r_re    <= 1'b0;
            r_we    <= 1'b1;
            r_addr  <= elem_addr(CB, r_i, r_j, NW);
            r_wdata <= w_acc_next;
          end
        end
        WRITE: begin
          r_k     <= '0;
          r_we    <= 1'b0;
          r_wdata <= '0;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              r_i     <= '0;
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_addr  <= '0;
            end else begin
              r_i     <= r_i + 32'd1;
              r_state <= READ_A;
              r_re    <= 1'b1;
              r_addr  <= elem_addr(AB, r_i + 32'd1, '0, NW);
            end
          end else begin
            r_j     <= r_j + 32'd1;
            r_state <= READ_A;
            r_re    <= 1'b1;
            r_addr  <= elem_addr(AB, r_i, '0, NW);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_re    <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
          r_wdata <= '0;
        end
      endcase
    end
  end

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.overflow         = w_overflow;
  assign bus.mem_address      = r_addr;
  assign bus.mem_write_data   = r_wdata;
  assign bus.mem_write_enable = r_we;
  assign bus.mem_read_enable  = r_re;

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Self-checking bench for matrix_mult_engine: cycle-level expected trace plus result memory checks.
module tb_matrix_mult_engine;
  import matmul_pkg::*;

  localparam int N  = 3;
  localparam int AB = 0;
  localparam int BB = 9;
  localparam int CB = 18;
`ifdef MATMUL_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        re;
    logic        we;
    logic        ovf;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ld;
  logic chk_en;
  logic [31:0] mem [64];
  logic [31:0] img [64];
  logic [31:0] exp_c [9];
  logic exp_ovf_hold;
  cyc_t exp_q [$];
  int checks = 0;
  int errors = 0;

  matrix_mult_engine_if bus();

  matrix_mult_engine #(
    .N      (N),
    .A_BASE (AB),
    .B_BASE (BB),
    .C_BASE (CB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[5:0]];

  always @(posedge clk) begin
    if (ld) begin
      for (int a = 0; a < 64; a++) mem[a] <= img[a];
    end else if (bus.mem_write_enable) begin
      mem[bus.mem_address[5:0]] <= bus.mem_write_data;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  function automatic cyc_t mk(input logic b, input logic d, input logic r, input logic w,
                              input logic o, input logic [31:0] ad, input logic [31:0] wd);
    cyc_t e;
    e.busy = b; e.done = d; e.re = r; e.we = w; e.ovf = o; e.addr = ad; e.wdata = wd;
    return e;
  endfunction

  // Expected per-cycle outputs and final C, from the row-major MAC definition.
  function automatic void build_model();
    logic        ov;
    logic [31:0] acc, a, b;
    logic [63:0] p;
    logic [32:0] s;
    exp_q.delete();
    ov = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
          a = img[AB + i*N + k];
          b = img[BB + k*N + j];
          exp_q.push_back(mk(1, 0, 1, 0, ov, 32'(AB + i*N + k), '0));
          exp_q.push_back(mk(1, 0, 1, 0, ov, 32'(BB + k*N + j), '0));
          p = {32'd0, a} * {32'd0, b};
          s = {1'b0, acc} + {1'b0, p[31:0]};
          if (OVF_EN && ((p[63:32] != 0) || s[32])) ov = 1'b1;
          acc = s[31:0];
        end
        exp_q.push_back(mk(1, 0, 0, 1, ov, 32'(CB + i*N + j), acc));
        exp_c[i*N + j] = acc;
      end
    end
    exp_q.push_back(mk(0, 1, 0, 0, ov, '0, '0));
    exp_ovf_hold = ov;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cyc_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(0, 0, 0, 0, exp_ovf_hold, '0, '0);
      check("ctl", 32'({bus.busy, bus.done, bus.mem_read_enable, bus.mem_write_enable, bus.overflow}),
                   32'({e.busy, e.done, e.re, e.we, e.ovf}));
      check("addr", bus.mem_address, e.addr);
      check("wdata", bus.mem_write_data, e.wdata);
    end
  end

  task automatic load_image();
    @(negedge clk); #1;
    ld = 1'b1;
    @(negedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic run(input bit hold, output int busy_c, output int done_i, output int wr);
    load_image();
    build_model();
    bus.start = 1'b1;
    busy_c = 0; done_i = 0; wr = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1 && !hold) bus.start = 1'b0;
      if (bus.busy) busy_c++;
      if (bus.mem_write_enable) wr++;
      if (bus.done) done_i = cyc;
      if (hold && done_i > 0 && cyc == done_i + 1) bus.start = 1'b0;
      if (done_i > 0 && cyc >= done_i + 3) break;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(done_i != 0), 32'd1);
    check("q_drained", 32'(exp_q.size()), 32'd0);
    for (int e = 0; e < 9; e++) check("c_mem", mem[CB + e], exp_c[e]);
  endtask

  task automatic clear_ab();
    for (int a = 0; a < 64; a++) img[a] = '0;
  endtask

  initial begin
    int bc, di, wr;
    logic [31:0] lit [9];
    rst_n = 1'b0; bus.start = 1'b0; ld = 1'b0; chk_en = 1'b0; exp_ovf_hold = 1'b0;
    clear_ab();
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({bus.busy, bus.done, bus.mem_read_enable, bus.mem_write_enable, bus.overflow}), '0);
    check("rst_addr", bus.mem_address, '0);
    check("rst_wdata", bus.mem_write_data, '0);
    rst_n = 1'b1;
    #1 chk_en = 1'b1;

    // Rows of A and B all [1,2,3]
    clear_ab();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        img[AB + r*3 + c] = 32'(c + 1);
        img[BB + r*3 + c] = 32'(c + 1);
      end
    run(0, bc, di, wr);
    lit = '{6, 12, 18, 6, 12, 18, 6, 12, 18};
    for (int e = 0; e < 9; e++) check("rows123_lit", mem[CB + e], lit[e]);
    check("busy_cycles", 32'(bc), 32'd63);
    check("done_after_busy", 32'(di), 32'(bc + 1));
    check("writes_rows", 32'(wr), 32'd9);

    // Identity A, B = 1..9
    clear_ab();
    for (int e = 0; e < 9; e++) img[BB + e] = 32'(e + 1);
    img[AB + 0] = 1; img[AB + 4] = 1; img[AB + 8] = 1;
    run(0, bc, di, wr);
    for (int e = 0; e < 9; e++) check("ident_lit", mem[CB + e], 32'(e + 1));
    check("writes_ident", 32'(wr), 32'd9);

    // start held high through busy and DONE
    clear_ab();
    for (int e = 0; e < 18; e++) img[e] = $urandom_range(0, 50);
    run(1, bc, di, wr);
    check("hold_writes", 32'(wr), 32'd9);
    check("hold_busy", 32'(bc), 32'd63);

    // 2^16 * 2^16 wraps to 0
    clear_ab();
    img[AB] = 32'h0001_0000; img[BB] = 32'h0001_0000;
    run(0, bc, di, wr);
    check("ovf16_c00", mem[CB], 32'd0);
    check("ovf16_flag", 32'(bus.overflow), 32'(OVF_EN));

    // All ones: each product is 1 mod 2^32
    for (int e = 0; e < 18; e++) img[e] = 32'hFFFF_FFFF;
    run(0, bc, di, wr);
    for (int e = 0; e < 9; e++) check("ones_lit", mem[CB + e], 32'd3);
    check("ones_flag", 32'(bus.overflow), 32'(OVF_EN));

    // Randomised runs: small values first (flag must clear), then full range
    for (int r = 0; r < 4; r++) begin
      clear_ab();
      for (int e = 0; e < 18; e++) img[e] = (r < 3) ? 32'($urandom_range(0, 2000)) : $urandom;
      run(0, bc, di, wr);
      check("rand_writes", 32'(wr), 32'd9);
    end

    // Reset in busy cycle 20: no further writes, earlier C writes kept
    chk_en = 1'b0;
    clear_ab();
    for (int e = 0; e < 18; e++) img[e] = $urandom_range(1, 100);
    for (int e = 0; e < 9; e++) img[CB + e] = 32'hC0DE_0000 + 32'(e);
    load_image();
    build_model();
    exp_q.delete();
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("arst_ctl", 32'({bus.busy, bus.done, bus.mem_read_enable, bus.mem_write_enable, bus.overflow}), '0);
    check("arst_addr", bus.mem_address, '0);
    check("arst_wdata", bus.mem_write_data, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("arst_c0", mem[CB + 0], exp_c[0]);
    check("arst_c1", mem[CB + 1], exp_c[1]);
    for (int e = 3; e < 9; e++) check("arst_keep", mem[CB + e], 32'hC0DE_0000 + 32'(e));
    exp_ovf_hold = 1'b0;
    #1 chk_en = 1'b1;

    clear_ab();
    for (int e = 0; e < 18; e++) img[e] = $urandom_range(0, 300);
    run(0, bc, di, wr);
    check("post_rst_writes", 32'(wr), 32'd9);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_mult_engine.md
MATRIX_MULT_ENGINE -- requirements
Module: matrix_mult_engine

Interface
- REQ-001: Parameter N, default 3, square matrix dimension (N >= 1).
- REQ-002: Parameter A_BASE, default 0, word address of A[0][0].
- REQ-003: Parameter B_BASE, default 9, word address of B[0][0].
- REQ-004: Parameter C_BASE, default 18, word address of C[0][0].
- REQ-005: clk  in  1  single clock; all state changes on rising edge.
- REQ-006: rst_n  in  1  asynchronous, active-low reset.
- REQ-007: start  in  1  request to compute C = A*B.
- REQ-008: busy  out  1  high while a computation is in progress.
- REQ-009: done  out  1  one-cycle completion pulse.
- REQ-010: mem_address  out  32  word address to data memory.
- REQ-011: mem_write_data  out  32  write data to data memory.
- REQ-012: mem_write_enable  out  1  memory write strobe, committed at rising edge.
- REQ-013: mem_read_enable  out  1  memory read strobe.
- REQ-014: mem_read_data  in  32  combinational read data, valid in the same cycle as mem_address/mem_read_enable.
- REQ-015: overflow  out  1  sticky arithmetic overflow flag.

Function
- REQ-016: FSM states SHALL be IDLE, READ_A, READ_B, WRITE, DONE.
- REQ-017: Matrices are row-major, one element per word: A[i][k] at A_BASE+i*N+k, B[k][j] at B_BASE+k*N+j, C[i][j] at C_BASE+i*N+j.
- REQ-018: IDLE with start=1 at an edge -> READ_A with i=j=k=0 and accumulator=0; start is ignored in all other states.
- REQ-019: READ_A: mem_address = A address, mem_read_enable=1; mem_read_data is latched into operand register at the edge; -> READ_B.
- REQ-020: READ_B: mem_address = B address, mem_read_enable=1; at the edge accumulator += operand*mem_read_data; k<N-1 -> READ_A with k+1, else -> WRITE.
- REQ-021: WRITE: mem_address = C address, mem_write_data = accumulator, mem_write_enable=1; accumulator and k clear; j advances, wrapping to 0 with i+1; after i=j=N-1 -> DONE, else -> READ_A.
- REQ-022: DONE: done=1 for exactly one cycle, then -> IDLE.
- REQ-023: busy=1 in READ_A, READ_B, WRITE; 0 in IDLE and DONE.
- REQ-024: Total busy cycles = N*N*(2N+1) (63 for N=3); done asserts in the cycle after the last WRITE.
- REQ-025: Product and sum are unsigned, truncated to low 32 bits (modulo 2^32).
- REQ-026: Outside READ_A/READ_B/WRITE, mem_address, mem_write_data, mem_write_enable and mem_read_enable are 0; read and write enables are never high together.
- REQ-027: Overlap of source and destination regions is not checked; C writes take effect immediately.

Reset
- REQ-028: rst_n low SHALL immediately force IDLE; busy, done, overflow, all mem_* outputs, indices, operand and accumulator go to 0.
- REQ-029: Reset mid-computation aborts with no further memory writes; earlier C writes remain.

Configuration
- REQ-030: With MATMUL_OVF_FLAG_EN defined, overflow sets when any 64-bit product or 33-bit sum exceeds 32 bits, clears on the start-accepting edge, and holds otherwise.
- REQ-031: Without MATMUL_OVF_FLAG_EN, overflow is tied to 0 and no overflow detection logic is built.

Structure
- REQ-032: Package matmul_pkg holds the state enum, the default N, and the A/B/C base-address constants.
- REQ-033: Sub-module mac_unit holds the operand/accumulator registers, the multiply-add, and the overflow detection.

Verification
- REQ-034: Memory rows A and B all [1,2,3], start pulse -> C words 18..26 = 6,12,18,6,12,18,6,12,18; done pulse 64 cycles after start edge.
- REQ-035: Identity A, B = 1..9 -> C equals B; exactly 9 writes, each in the cycle following the READ_B of k=2.
- REQ-036: start held high through busy and DONE -> single computation, second run starts only from IDLE.
- REQ-037: rst_n low in cycle 20 -> outputs 0 asynchronously; C words 21..26 unchanged from pre-start values.
- REQ-038: A[0][0]=B[0][0]=32'h0001_0000, remaining inputs 0 -> C[0][0]=0; overflow=1 with MATMUL_OVF_FLAG_EN, 0 without.
- REQ-039: A and B all 32'hFFFF_FFFF -> C elements = 32'h0000_0003 (modulo wrap); overflow=1 with MATMUL_OVF_FLAG_EN.
